rpn_ctrl: RTL

- Reverse-Polish-Notation evaluator that sits directly upstream of the LIFO stack.
- Drives the stack's push/pop interface and consumes its pop data and full/empty flags.
- Accepts a valid/ready token stream of operands and opcodes, and computes results on the stack.
- Emits results and error reports on a valid/ready result stream.

---
 rtl/rpn_pkg.sv | 30 +++
 rtl/rpn_alu.sv | 27 ++
 rtl/rpn_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN evaluator.
package rpn_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_DUP  = 4'd6,
      OP_DROP = 4'd7,
      OP_EMIT = 4'd8,
      OP_CLR  = 4'd9
   } opcode_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EXEC  = 3'd1,
      BIN2  = 3'd2,
      OUT   = 3'd3,
      ERR   = 3'd4,
      DRAIN = 3'd5
   } state_t;

   localparam logic [3:0] ERR_UNF = 4'd1;
   localparam logic [3:0] ERR_OVF = 4'd2;
   localparam logic [3:0] ERR_ILL = 4'd3;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the binary RPN opcodes; results wrap modulo 2^DW.
module rpn_alu
   import rpn_pkg::*;
#(
   parameter int DW = 8
) (
   input  opcode_t         op,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [DW-1:0]   y
);

   // Select the result of A op B; non-ALU opcodes give zero.
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_MUL:  y = a * b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/rpn_ctrl.sv
// RPN evaluator driving an external LIFO stack.
//
// state | meaning
// IDLE  | waiting for a token
// EXEC  | execute the registered token against the stack
// BIN2  | second operand fetch for a binary op, write back result
// OUT   | holding a result or error report until accepted
// ERR   | error latched; tokens discarded until CLR
// DRAIN | popping the stack until empty
module rpn_ctrl
   import rpn_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_tok_valid,
   output logic            o_tok_ready,
   input  logic            i_tok_is_op,
   input  logic [DW-1:0]   i_tok_data,
   output logic            o_res_valid,
   input  logic            i_res_ready,
   output logic [DW-1:0]   o_res_data,
   output logic            o_res_err,
   output logic            o_stk_push_en,
   output logic [DW-1:0]   o_stk_push_data,
   input  logic            i_stk_full,
   output logic            o_stk_pop_en,
   input  logic [DW-1:0]   i_stk_pop_data,
   input  logic            i_stk_empty
);

   state_t          state;
   logic            tok_is_op;
   logic [DW-1:0]   tok_data;
   logic [DW-1:0]   b_ff;
   logic            err_pend;
   logic [DW-1:0]   alu_y;
   logic            err_now;
   logic [3:0]      err_code;
   opcode_t         opc;

   assign opc = opcode_t'(tok_data[3:0]);

   rpn_alu #(.DW(DW)) u_alu (
      .op (opc),
      .a  (i_stk_pop_data),
      .b  (b_ff),
      .y  (alu_y)
   );

   // Decode stack commands and error conditions from state and the held token.
   always_comb begin
      o_stk_push_en   = 1'b0;
      o_stk_pop_en    = 1'b0;
      o_stk_push_data = tok_data;
      err_now         = 1'b0;
      err_code        = 4'd0;
      case (state)
         EXEC: begin
            if (!tok_is_op) begin
               if (i_stk_full) begin
                  err_now  = 1'b1;
                  err_code = ERR_OVF;
               end else begin
                  o_stk_push_en = 1'b1;
               end
            end else begin
               case (opc)
                  OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR,
                  OP_DROP, OP_EMIT: begin
                     if (i_stk_empty) begin
                        err_now  = 1'b1;
                        err_code = ERR_UNF;
                     end else begin
                        o_stk_pop_en = 1'b1;
                     end
                  end
                  OP_DUP: begin
                     if (i_stk_empty) begin
                        err_now  = 1'b1;
                        err_code = ERR_UNF;
                     end else if (i_stk_full) begin
                        err_now  = 1'b1;
                        err_code = ERR_OVF;
                     end else begin
                        o_stk_push_en   = 1'b1;
                        o_stk_push_data = i_stk_pop_data;
                     end
                  end
                  OP_CLR: ;
                  default: begin
                     err_now  = 1'b1;
                     err_code = ERR_ILL;
                  end
               endcase
            end
         end
         BIN2: begin
            if (i_stk_empty) begin
               err_now  = 1'b1;
               err_code = ERR_UNF;
            end else begin
               // push+pop together replaces A with the result
               o_stk_push_en   = 1'b1;
               o_stk_pop_en    = 1'b1;
               o_stk_push_data = alu_y;
            end
         end
         DRAIN: o_stk_pop_en = !i_stk_empty;
         default: ;
      endcase
   end

   // Main FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tok_is_op   <= 1'b0;
         tok_data    <= '0;
         b_ff        <= '0;
         err_pend    <= 1'b0;
         o_tok_ready <= 1'b1;
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_tok_valid) begin
                  tok_is_op   <= i_tok_is_op;
                  tok_data    <= i_tok_data;
                  o_tok_ready <= 1'b0;
                  state       <= EXEC;
               end
            end
            EXEC, BIN2: begin
               if (err_now) begin
                  o_res_data  <= DW'(err_code);
                  o_res_err   <= 1'b1;
                  o_res_valid <= 1'b1;
                  err_pend    <= 1'b1;
                  state       <= OUT;
               end else if (state == BIN2 || !tok_is_op) begin
                  o_tok_ready <= 1'b1;
                  state       <= IDLE;
               end else begin
                  case (opc)
                     OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                        b_ff  <= i_stk_pop_data;
                        state <= BIN2;
                     end
                     OP_EMIT: begin
                        o_res_data  <= i_stk_pop_data;
                        o_res_err   <= 1'b0;
                        o_res_valid <= 1'b1;
                        state       <= OUT;
                     end
                     OP_CLR:  state <= DRAIN;
                     default: begin
                        o_tok_ready <= 1'b1;
                        state       <= IDLE;
                     end
                  endcase
               end
            end
            OUT: begin
               if (i_res_ready) begin
                  o_res_valid <= 1'b0;
                  o_tok_ready <= 1'b1;
                  state       <= err_pend ? ERR : IDLE;
               end
            end
            ERR: begin
               if (i_tok_valid && i_tok_is_op && i_tok_data[3:0] == OP_CLR) begin
                  o_tok_ready <= 1'b0;
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               if (i_stk_empty) begin
                  err_pend    <= 1'b0;
                  o_tok_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               o_tok_ready <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
